// File: rtl/cnt_pkg.sv
// Shared constants for the modulo-N counter slice.
// Direction and bound-mode encodings used by cnt_modn and its bench.
package cnt_pkg;

   localparam logic CNT_UP   = 1'b1;
   localparam logic CNT_DOWN = 1'b0;

   localparam int CNT_WRAP = 0;
   localparam int CNT_SAT  = 1;

endpackage

// File: rtl/cnt_prescale.sv
// Enable prescaler: emits one step per PRESCALE enabled cycles.
// Partial counts are discarded on rst or clr.
module cnt_prescale #(
   parameter int PRESCALE = 1
) (
   input  logic clk,
   input  logic rst,
   input  logic clr,
   input  logic en,
   output logic step
);

   localparam int PW = (PRESCALE > 1) ? $clog2(PRESCALE) : 1;
   localparam logic [PW-1:0] LAST = PW'(PRESCALE - 1);

   logic [PW-1:0] r_pcnt;
   logic          w_last;

   // With PRESCALE=1 the counter never leaves 0, so step follows en.
   assign w_last = (r_pcnt == LAST);
   assign step   = en & w_last;

   always_ff @(posedge clk) begin
      if (rst || clr) begin
         r_pcnt <= '0;
      end else if (en) begin
         if (w_last) r_pcnt <= '0;
         else        r_pcnt <= r_pcnt + PW'(1);
      end
   end

endmodule

// File: rtl/cnt_modn.sv
// Up/down modulo-N counter with load, prescaler, wrap or saturate mode.
// tc is combinational from cnt and up; wrap is a registered pulse.
import cnt_pkg::*;

module cnt_modn #(
   parameter int WIDTH    = 8,
   parameter int MODULUS  = 16,
   parameter int SAT      = 0,
   parameter int PRESCALE = 1
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             en,
   input  logic             up,
   input  logic             load,
   input  logic [WIDTH-1:0] load_val,
   output logic [WIDTH-1:0] cnt,
   output logic             tc,
   output logic             wrap
);

   localparam logic [WIDTH-1:0] MAXV = WIDTH'(MODULUS - 1);

   logic [WIDTH-1:0] r_cnt;
   logic             r_wrap;
   logic [WIDTH-1:0] w_next;
   logic [WIDTH-1:0] w_ld;
   logic             w_step;
   logic             w_top;
   logic             w_bot;
   logic             w_tc;

   cnt_prescale #(
      .PRESCALE (PRESCALE)
   ) u_pre (
      .clk  (clk),
      .rst  (rst),
      .clr  (load),
      .en   (en),
      .step (w_step)
   );

   assign w_top = (r_cnt == MAXV);
   assign w_bot = (r_cnt == '0);
   assign w_tc  = (up == CNT_UP) ? w_top : w_bot;
   assign w_ld  = (load_val > MAXV) ? MAXV : load_val;

   // At a bound the counter either holds (SAT) or jumps to the other bound.
   always_comb begin
      w_next = r_cnt;
      if (up == CNT_UP) begin
         if (!w_top)              w_next = r_cnt + WIDTH'(1);
         else if (SAT != CNT_SAT) w_next = '0;
      end else begin
         if (!w_bot)              w_next = r_cnt - WIDTH'(1);
         else if (SAT != CNT_SAT) w_next = MAXV;
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         r_cnt  <= '0;
         r_wrap <= 1'b0;
      end else if (load) begin
         r_cnt  <= w_ld;
         r_wrap <= 1'b0;
      end else begin
         r_wrap <= w_step & w_tc;
         if (w_step) r_cnt <= w_next;
      end
   end

   assign cnt  = r_cnt;
   assign tc   = w_tc;
   assign wrap = r_wrap;

endmodule

// File: tb/tb_cnt_modn.sv
// Scoreboard bench for cnt_modn: three instances (wrap, saturate, prescale 3).
// Each row gives inputs and the outputs expected during that cycle.
`timescale 1ns/1ps
module tb_cnt_modn;

   typedef struct {
      int         row;
      int         id;
      logic [3:0] cnt;
      logic       tc;
      logic       wrap;
   } exp_t;

   logic       clk = 1'b0;
   logic [2:0] rst;
   logic [2:0] en;
   logic [2:0] up;
   logic [2:0] load;
   logic [3:0] lv [3];
   logic [3:0] cnt [3];
   logic [2:0] tc;
   logic [2:0] wrap;

   exp_t q [$];
   int   total = 0;
   int   bad   = 0;
   int   row   = 0;

   always #5 clk = ~clk;

   cnt_modn #(.WIDTH(4), .MODULUS(10), .SAT(0), .PRESCALE(1)) d0 (
      .clk(clk), .rst(rst[0]), .en(en[0]), .up(up[0]), .load(load[0]),
      .load_val(lv[0]), .cnt(cnt[0]), .tc(tc[0]), .wrap(wrap[0]));

   cnt_modn #(.WIDTH(4), .MODULUS(10), .SAT(1), .PRESCALE(1)) d1 (
      .clk(clk), .rst(rst[1]), .en(en[1]), .up(up[1]), .load(load[1]),
      .load_val(lv[1]), .cnt(cnt[1]), .tc(tc[1]), .wrap(wrap[1]));

   cnt_modn #(.WIDTH(4), .MODULUS(10), .SAT(0), .PRESCALE(3)) d2 (
      .clk(clk), .rst(rst[2]), .en(en[2]), .up(up[2]), .load(load[2]),
      .load_val(lv[2]), .cnt(cnt[2]), .tc(tc[2]), .wrap(wrap[2]));

   // Monitor: one expected entry is consumed per cycle, mid-cycle.
   always @(negedge clk) begin
      if (q.size() > 0) begin
         exp_t e;
         e = q.pop_front();
         total++;
         if (cnt[e.id] !== e.cnt || tc[e.id] !== e.tc ||
             wrap[e.id] !== e.wrap) begin
            bad++;
            $display("FAIL row%0d dut%0d got cnt=%0d tc=%0b wrap=%0b want cnt=%0d tc=%0b wrap=%0b",
                     e.row, e.id, cnt[e.id], tc[e.id], wrap[e.id],
                     e.cnt, e.tc, e.wrap);
         end
      end
   end

   task automatic cyc(input int id, input logic r, input logic e,
                      input logic u, input logic l, input logic [3:0] v,
                      input logic [3:0] ec, input logic et,
                      input logic ew);
      exp_t x;
      rst[id]  = r;
      en[id]   = e;
      up[id]   = u;
      load[id] = l;
      lv[id]   = v;
      x.row  = row;
      x.id   = id;
      x.cnt  = ec;
      x.tc   = et;
      x.wrap = ew;
      q.push_back(x);
      row++;
      @(posedge clk);
      #1;
   endtask

   initial begin
      rst  = 3'b111;
      en   = 3'b000;
      up   = 3'b111;
      load = 3'b000;
      for (int i = 0; i < 3; i++) lv[i] = 4'd0;
      repeat (2) @(posedge clk);
      #1;

      // dut0: reset state, then count 0..9,0,1 with wrap after 9
      cyc(0, 1, 0, 1, 0, 0, 0, 0, 0);
      for (int k = 0; k < 12; k++)
         cyc(0, 0, 1, 1, 0, 0, 4'(k % 10), (k == 9), (k == 10));
      cyc(0, 0, 0, 1, 0, 0, 2, 0, 0);
      // direction change at 5: 6 then 5,4
      cyc(0, 0, 0, 1, 1, 5, 2, 0, 0);
      cyc(0, 0, 1, 1, 0, 0, 5, 0, 0);
      cyc(0, 0, 1, 0, 0, 0, 6, 0, 0);
      cyc(0, 0, 1, 0, 0, 0, 5, 0, 0);
      cyc(0, 0, 0, 0, 0, 0, 4, 0, 0);
      // tc follows up at cnt=0, then down-wrap to 9
      cyc(0, 0, 0, 0, 1, 0, 4, 0, 0);
      cyc(0, 0, 0, 0, 0, 0, 0, 1, 0);
      cyc(0, 0, 0, 1, 0, 0, 0, 0, 0);
      cyc(0, 0, 1, 0, 0, 0, 0, 1, 0);
      cyc(0, 0, 0, 0, 0, 0, 9, 0, 1);
      // load beats step at tc, no wrap; load 13 clamps to 9
      cyc(0, 0, 1, 1, 1, 3, 9, 1, 0);
      cyc(0, 0, 0, 1, 0, 0, 3, 0, 0);
      cyc(0, 0, 0, 1, 1, 13, 3, 0, 0);
      cyc(0, 0, 0, 1, 0, 0, 9, 1, 0);

      // dut1 saturating: down from 2 -> 1,0,0,0 with two wrap pulses
      cyc(1, 0, 0, 0, 1, 2, 0, 1, 0);
      cyc(1, 0, 1, 0, 0, 0, 2, 0, 0);
      cyc(1, 0, 1, 0, 0, 0, 1, 0, 0);
      cyc(1, 0, 1, 0, 0, 0, 0, 1, 0);
      cyc(1, 0, 1, 0, 0, 0, 0, 1, 1);
      cyc(1, 0, 0, 0, 0, 0, 0, 1, 1);
      cyc(1, 0, 0, 0, 0, 0, 0, 1, 0);
      // saturate at top
      cyc(1, 0, 0, 1, 1, 9, 0, 0, 0);
      cyc(1, 0, 1, 1, 0, 0, 9, 1, 0);
      cyc(1, 0, 0, 1, 0, 0, 9, 1, 1);
      cyc(1, 0, 0, 1, 0, 0, 9, 1, 0);

      // dut2 prescale 3: step every 3rd enabled cycle
      cyc(2, 0, 1, 1, 0, 0, 0, 0, 0);
      cyc(2, 0, 1, 1, 0, 0, 0, 0, 0);
      cyc(2, 0, 1, 1, 0, 0, 0, 0, 0);
      cyc(2, 0, 1, 1, 0, 0, 1, 0, 0);
      cyc(2, 0, 1, 1, 0, 0, 1, 0, 0);
      cyc(2, 0, 1, 1, 0, 0, 1, 0, 0);
      // en low 2 cycles mid-period delays the step by 2
      cyc(2, 0, 1, 1, 0, 0, 2, 0, 0);
      cyc(2, 0, 0, 1, 0, 0, 2, 0, 0);
      cyc(2, 0, 0, 1, 0, 0, 2, 0, 0);
      cyc(2, 0, 1, 1, 0, 0, 2, 0, 0);
      cyc(2, 0, 1, 1, 0, 0, 2, 0, 0);
      cyc(2, 0, 0, 1, 0, 0, 3, 0, 0);
      // rst at cnt=7 with load and partial prescale
      cyc(2, 0, 0, 1, 1, 7, 3, 0, 0);
      cyc(2, 0, 1, 1, 0, 0, 7, 0, 0);
      cyc(2, 1, 1, 1, 1, 5, 7, 0, 0);
      cyc(2, 1, 0, 0, 0, 0, 0, 1, 0);
      cyc(2, 0, 1, 1, 0, 0, 0, 0, 0);
      cyc(2, 0, 1, 1, 0, 0, 0, 0, 0);
      cyc(2, 0, 1, 1, 0, 0, 0, 0, 0);
      cyc(2, 0, 0, 1, 0, 0, 1, 0, 0);

      for (int i = 0; i < 5 && q.size() > 0; i++) @(negedge clk);
      if (q.size() > 0) begin
         bad++;
         $display("FAIL drain left=%0d want 0", q.size());
      end
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
